// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the hazard scoreboard and the forwarding logic.
package hazard_scoreboard_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned LAT_W     = 4;
    localparam int unsigned WSEL_W    = 2;

    // EX write target encoding
    typedef enum logic [WSEL_W-1:0] {
        WSEL_NONE = 2'b00,
        WSEL_REG  = 2'b01,
        WSEL_MROW = 2'b10,
        WSEL_MALL = 2'b11
    } wsel_e;

    // Matrix unit occupancy state
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Outstanding matrix write: remaining cycles and target rows
    typedef struct packed {
        logic [LAT_W-1:0]     cnt;
        logic [REG_IDX_W-1:0] row;
        logic                 all;
    } pend_t;

    // Both matrix encodings have the upper bit set
    function automatic logic is_mat_write(input wsel_e wsel);
        return (wsel == WSEL_MROW) || (wsel == WSEL_MALL);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_stall_perf_counter.sv
// Saturating event counter used to count stall cycles.
module stall_perf_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] COUNT_MAX = {W{1'b1}};

    // Count up on each event, hold at the maximum value
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != COUNT_MAX)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use and matrix-unit hazard detection with stall generation.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [4:0]             id_rs1,
    input  logic                   id_rs1_used,
    input  logic [4:0]             id_rs2,
    input  logic                   id_rs2_r_select,
    input  logic                   id_mat_op,
    input  logic                   ex_valid,
    input  logic [4:0]             ex_rd,
    input  logic [1:0]             ex_w_select,
    input  logic                   ex_mem_read,
    input  logic [3:0]             ex_mat_latency,
    output logic                   stall_if,
    output logic                   stall_id,
    output logic                   bubble_ex,
    output logic                   mat_busy,
    output logic                   mat_overlap_err,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    state_e state_q, state_d;
    pend_t  pend_q, pend_d;
    logic   err_d;
    wsel_e  ex_wsel;
    logic   mat_in_ex;
    logic   mat_start;
    logic   load_use;
    logic   mat_hazard;
    logic   stall;

    assign ex_wsel   = wsel_e'(ex_w_select);
    assign mat_in_ex = ex_valid && is_mat_write(ex_wsel);
    // Zero-latency matrix ops are fully covered by forwarding
    assign mat_start = mat_in_ex && (ex_mat_latency != LAT_W'(0));

    // Hazard detection and stall combine; reset forces all stall outputs low
    always_comb begin
        load_use = ex_valid && ex_mem_read && (ex_wsel == WSEL_REG) &&
                   (ex_rd != REG_IDX_W'(0)) &&
                   ((id_rs1_used && (ex_rd == id_rs1)) ||
                    (id_rs2_r_select && (ex_rd == id_rs2)));
        mat_hazard = (state_q == ST_BUSY) && id_valid &&
                     (id_mat_op ||
                      (!id_rs2_r_select && (pend_q.all || (pend_q.row == id_rs2))));
        stall = !rst && id_valid && (load_use || mat_hazard);
    end

    assign stall_if  = stall;
    assign stall_id  = stall;
    assign bubble_ex = stall;
    assign mat_busy  = !rst && (state_q == ST_BUSY);

    // Next-state: start countdown on a matrix op, release when it expires
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        err_d   = mat_overlap_err;
        case (state_q)
            ST_IDLE: begin
                if (mat_start) begin
                    state_d    = ST_BUSY;
                    pend_d.cnt = ex_mat_latency;
                    pend_d.row = ex_rd;
                    pend_d.all = (ex_wsel == WSEL_MALL);
                end
            end
            ST_BUSY: begin
                // A second matrix op here is a pipeline bug; keep tracking the first
                if (mat_in_ex) begin
                    err_d = 1'b1;
                end
                if (pend_q.cnt == LAT_W'(1)) begin
                    state_d    = ST_IDLE;
                    pend_d.cnt = '0;
                    pend_d.all = 1'b0;
                end else begin
                    pend_d.cnt = pend_q.cnt - LAT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Scoreboard state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            pend_q          <= '0;
            mat_overlap_err <= 1'b0;
        end else begin
            state_q         <= state_d;
            pend_q          <= pend_d;
            mat_overlap_err <= err_d;
        end
    end

    stall_perf_counter #(
        .W(STALL_CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall),
        .count (stall_cycles)
    );

endmodule
